// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM ROM loader: write FSM states and FIFO entry.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP
  } wr_state_t;

  typedef struct packed {
    logic [26:1] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } fifo_entry_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_FULL = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count; accepts up to two pushes
// per cycle (slot 0 is written first) and one pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0,
  input  logic [WIDTH-1:0]         din0,
  input  logic                     wr1,
  input  logic [WIDTH-1:0]         din1,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    wptr1;
  logic [AW-1:0]    rptr;
  logic [AW:0]      n_in;

  assign wptr1 = wptr + AW'(wr0);
  assign n_in  = {{AW{1'b0}}, wr0} + {{AW{1'b0}}, wr1};
  assign dout  = mem[rptr];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (wr0) mem[wptr] <= din0;
    if (wr1) mem[wptr1] <= din1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr0) + AW'(wr1);
      rptr  <= rptr + AW'(rd);
      count <= count + n_in - {{AW{1'b0}}, rd};
    end
  end

endmodule

// File: rtl/sdram_rom_loader.sv
// Packs download bytes into 16-bit SDRAM writes and feeds them to the
// controller's write channel through a small FIFO and a req/ack FSM.
module sdram_rom_loader
  import sdram_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [25:0] BASE_ADDR  = 26'h0
) (
  input  logic        clk,
  input  logic        init,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [26:1] ch3_addr,
  output logic [15:0] ch3_din,
  output logic [1:0]  ch3_be,
  output logic        ch3_req,
  output logic        ch3_rnw,
  input  logic        ch3_ready,
  output logic        busy,
  output logic        done,
  output logic [23:0] words_written
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        dl_q;
  logic        dl_rise;
  logic        pend_valid;
  logic        pend_live;
  logic [26:0] pend_addr;
  logic [7:0]  pend_data;
  logic        pair;
  logic        flush;
  logic        odd_push;
  logic [25:0] new_waddr;
  logic [25:0] pend_waddr;

  fifo_entry_t pair_e;
  fifo_entry_t flush_e;
  fifo_entry_t odd_e;
  fifo_entry_t push0;
  fifo_entry_t head;
  logic        wr0;
  logic        wr1;
  logic        pop;
  logic        ack;
  logic        done_cond;
  logic [CW-1:0] count;
  logic        empty;

  wr_state_t state;
  wr_state_t state_n;

  assign ch3_rnw    = 1'b0;
  assign ioctl_wait = (count >= CW'(FIFO_DEPTH - 1));

  assign dl_rise    = ioctl_download & ~dl_q;
  assign pend_live  = pend_valid & ~dl_rise;
  assign new_waddr  = BASE_ADDR + ioctl_addr[26:1];
  assign pend_waddr = BASE_ADDR + pend_addr[26:1];

  // A held even byte leaves either paired with its odd neighbour or alone
  // (be=01) when anything else arrives or the download window closes.
  assign pair     = ioctl_wr & pend_live
                  & (ioctl_addr == pend_addr + 27'd1);
  assign flush    = pend_live & ~pair
                  & (ioctl_wr | ~ioctl_download);
  assign odd_push = ioctl_wr & ioctl_addr[0] & ~pair;

  assign pair_e  = '{addr: new_waddr,
                     data: {ioctl_dout, pend_data},
                     be:   BE_FULL};
  assign flush_e = '{addr: pend_waddr,
                     data: {8'h00, pend_data},
                     be:   BE_LO};
  assign odd_e   = '{addr: new_waddr,
                     data: {ioctl_dout, 8'h00},
                     be:   BE_HI};

  assign wr0   = pair | flush | odd_push;
  assign wr1   = flush & odd_push;
  assign push0 = pair  ? pair_e  :
                 flush ? flush_e : odd_e;

  sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (init),
    .wr0  (wr0),
    .din0 (push0),
    .wr1  (wr1),
    .din1 (odd_e),
    .rd   (pop),
    .dout (head),
    .count(count),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (init) begin
      dl_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_rise | pair | flush) pend_valid <= 1'b0;
      if (ioctl_wr & ~ioctl_addr[0]) begin
        pend_valid <= 1'b1;
        pend_addr  <= ioctl_addr;
        pend_data  <= ioctl_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ:  if (ch3_ready) state_n = ST_GAP;
      ST_GAP:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign ack       = (state == ST_REQ) & ch3_ready;
  assign done_cond = busy & ~ioctl_download & ~pend_valid
                   & empty & (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (init) begin
      ch3_req  <= 1'b0;
      ch3_addr <= '0;
      ch3_din  <= '0;
      ch3_be   <= '0;
    end else begin
      if (pop) begin
        ch3_req  <= 1'b1;
        ch3_addr <= head.addr;
        ch3_din  <= head.data;
        ch3_be   <= head.be;
      end
      if (ack) ch3_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      done <= done_cond & ~dl_rise;
      if (dl_rise)        busy <= 1'b1;
      else if (done_cond) busy <= 1'b0;
      if (dl_rise)  words_written <= {23'd0, ack};
      else if (ack) words_written <= words_written + 24'd1;
    end
  end

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Self-checking bench for sdram_rom_loader: table vectors, corner
// sequences and randomized downloads against a byte-packing model.
module tb_sdram_rom_loader;

  localparam logic [25:0] BASE = 26'h0001000;

  logic        clk = 1'b0;
  logic        init = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [26:1] ch3_addr;
  logic [15:0] ch3_din;
  logic [1:0]  ch3_be;
  logic        ch3_req;
  logic        ch3_rnw;
  logic        ch3_ready;
  logic        busy;
  logic        done;
  logic [23:0] words_written;

  logic auto_ready = 1'b0;
  logic man_ready = 1'b0;
  assign ch3_ready = auto_ready | man_ready;

  always #5 clk = ~clk;

  sdram_rom_loader #(
    .FIFO_DEPTH(4),
    .BASE_ADDR (BASE)
  ) dut (
    .clk           (clk),
    .init          (init),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .ch3_addr      (ch3_addr),
    .ch3_din       (ch3_din),
    .ch3_be        (ch3_be),
    .ch3_req       (ch3_req),
    .ch3_rnw       (ch3_rnw),
    .ch3_ready     (ch3_ready),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  typedef struct {
    logic [25:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
  } wr_t;

  typedef struct {
    int          n;
    logic [26:0] a0, a1;
    logic [7:0]  d0, d1;
    int          nw;
    logic [25:0] ea0, ea1;
    logic [15:0] ed0, ed1;
    logic [1:0]  eb0, eb1;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;

  wr_t obs[$];
  wr_t exp_q[$];
  wr_t cap;
  logic req_prev = 1'b0;
  int stab_viol = 0;
  int rnw_viol = 0;
  int done_cnt = 0;
  int wait_viol = 0;
  int ovf = 0;
  int wait_seen = 0;
  int pushed = 0;
  int popped = 0;
  bit bp_on = 1'b0;

  bit ack_en = 1'b1;
  int ack_delay = 0;
  bit ack_given = 1'b0;
  int wcnt = 0;

  // controller-side observer
  always @(negedge clk) begin
    if (ch3_req && !req_prev) begin
      cap = '{ch3_addr, ch3_din, ch3_be};
      obs.push_back(cap);
      if (bp_on) popped++;
    end else if (ch3_req && req_prev) begin
      if (ch3_addr != cap.addr || ch3_din != cap.din || ch3_be != cap.be)
        stab_viol++;
    end
    if (ch3_rnw) rnw_viol++;
    if (done) done_cnt++;
    if (bp_on) begin
      if (ioctl_wait != ((pushed - popped) >= 3)) wait_viol++;
      if (ioctl_wait) wait_seen = 1;
      if ((pushed - popped) > 4) ovf++;
      if (ioctl_wr && ioctl_addr[0]) pushed++;
    end
    req_prev = ch3_req;
  end

  // controller-side acknowledge generator
  always @(negedge clk) begin
    auto_ready = 1'b0;
    if (!ch3_req) begin
      ack_given = 1'b0;
      wcnt = 0;
    end else if (ack_en && !ack_given) begin
      if (wcnt >= ack_delay) begin
        auto_ready = 1'b1;
        ack_given = 1'b1;
      end else begin
        wcnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    int guard = 0;
    while (ioctl_wait && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) chk("wait_timeout", 64'd1, 64'd0);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  // Spec-level packing rule applied to a whole download's byte list.
  function automatic void model(input logic [26:0] a[$],
                                input logic [7:0] d[$]);
    bit pv = 1'b0;
    logic [26:0] pa = '0;
    logic [7:0]  pd = '0;
    logic [25:0] wa;
    exp_q.delete();
    foreach (a[i]) begin
      if (pv && a[i] == pa + 27'd1) begin
        wa = BASE + pa[26:1];
        exp_q.push_back('{wa, {d[i], pd}, 2'b11});
        pv = 1'b0;
      end else begin
        if (pv) begin
          wa = BASE + pa[26:1];
          exp_q.push_back('{wa, {8'h00, pd}, 2'b01});
          pv = 1'b0;
        end
        if (a[i][0]) begin
          wa = BASE + a[i][26:1];
          exp_q.push_back('{wa, {d[i], 8'h00}, 2'b10});
        end else begin
          pv = 1'b1;
          pa = a[i];
          pd = d[i];
        end
      end
    end
    if (pv) begin
      wa = BASE + pa[26:1];
      exp_q.push_back('{wa, {8'h00, pd}, 2'b01});
    end
  endfunction

  task automatic session(input logic [26:0] a[$], input logic [7:0] d[$],
                         input int gap, input string tag);
    int b0 = obs.size();
    int dn0 = done_cnt;
    int guard = 0;
    logic [15:0] m;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    foreach (a[i]) begin
      send_byte(a[i], d[i]);
      repeat ($urandom_range(0, gap)) begin
        @(posedge clk); #1;
      end
    end
    ioctl_download = 1'b0;
    while (done_cnt == dn0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({tag, "_nwrites"}, 64'(obs.size() - b0), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (b0 + i < obs.size()) begin
        m = {{8{exp_q[i].be[1]}}, {8{exp_q[i].be[0]}}};
        chk($sformatf("%s_addr%0d", tag, i),
            64'(obs[b0+i].addr), 64'(exp_q[i].addr));
        chk($sformatf("%s_be%0d", tag, i),
            64'(obs[b0+i].be), 64'(exp_q[i].be));
        chk($sformatf("%s_din%0d", tag, i),
            64'(obs[b0+i].din & m), 64'(exp_q[i].din & m));
      end
    end
    chk({tag, "_words"}, 64'(words_written), 64'(exp_q.size()));
    chk({tag, "_done"}, 64'(done_cnt - dn0), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  vec_t tbl[7];
  logic [26:0] aq[$];
  logic [7:0]  dq[$];

  task automatic set_vec(input int k, input int n,
                         input logic [26:0] a0, input logic [7:0] d0,
                         input logic [26:0] a1, input logic [7:0] d1,
                         input int nw,
                         input logic [25:0] ea0, input logic [15:0] ed0,
                         input logic [1:0] eb0,
                         input logic [25:0] ea1, input logic [15:0] ed1,
                         input logic [1:0] eb1);
    tbl[k] = '{n, a0, a1, d0, d1, nw, ea0, ea1, ed0, ed1, eb0, eb1};
  endtask

  initial begin
    int guard;
    int dn0;
    logic [26:0] cur;

    set_vec(0, 2, 27'h0, 8'h11, 27'h1, 8'h22, 1,
            26'h1000, 16'h2211, 2'b11, 26'h0, 16'h0, 2'b00);
    set_vec(1, 1, 27'h4, 8'hAA, 27'h0, 8'h00, 1,
            26'h1002, 16'h00AA, 2'b01, 26'h0, 16'h0, 2'b00);
    set_vec(2, 2, 27'h7, 8'h55, 27'hA, 8'h66, 2,
            26'h1003, 16'h5500, 2'b10, 26'h1005, 16'h0066, 2'b01);
    set_vec(3, 2, 27'h7FFFFFE, 8'h77, 27'h7FFFFFF, 8'h88, 1,
            26'h0FFF, 16'h8877, 2'b11, 26'h0, 16'h0, 2'b00);
    set_vec(4, 2, 27'h2, 8'h01, 27'h6, 8'h02, 2,
            26'h1001, 16'h0001, 2'b01, 26'h1003, 16'h0002, 2'b01);
    set_vec(5, 2, 27'h1, 8'h10, 27'h2, 8'h20, 2,
            26'h1000, 16'h1000, 2'b10, 26'h1001, 16'h0020, 2'b01);
    set_vec(6, 2, 27'h2, 8'h30, 27'h1, 8'h40, 2,
            26'h1001, 16'h0030, 2'b01, 26'h1000, 16'h4000, 2'b10);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_req", 64'(ch3_req), 64'd0);
    chk("rst_addr", 64'(ch3_addr), 64'd0);
    chk("rst_din", 64'(ch3_din), 64'd0);
    chk("rst_be", 64'(ch3_be), 64'd0);
    chk("rst_rnw", 64'(ch3_rnw), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    init = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      aq.delete();
      dq.delete();
      aq.push_back(tbl[k].a0);
      dq.push_back(tbl[k].d0);
      if (tbl[k].n > 1) begin
        aq.push_back(tbl[k].a1);
        dq.push_back(tbl[k].d1);
      end
      exp_q.delete();
      exp_q.push_back('{tbl[k].ea0, tbl[k].ed0, tbl[k].eb0});
      if (tbl[k].nw > 1) exp_q.push_back('{tbl[k].ea1, tbl[k].ed1, tbl[k].eb1});
      ack_delay = k % 3;
      session(aq, dq, k % 2, $sformatf("vec%0d", k));
    end

    // backpressure: 8 full words with a slow controller
    aq.delete();
    dq.delete();
    for (int i = 0; i < 16; i++) begin
      aq.push_back(27'(i));
      dq.push_back(8'(i * 3 + 1));
    end
    model(aq, dq);
    ack_delay = 10;
    bp_on = 1'b1;
    session(aq, dq, 0, "bp");
    bp_on = 1'b0;
    chk("bp_wait_seen", 64'(wait_seen), 64'd1);
    chk("bp_wait_level", 64'(wait_viol), 64'd0);
    chk("bp_overflow", 64'(ovf), 64'd0);

    // randomized downloads
    for (int s = 0; s < 8; s++) begin
      aq.delete();
      dq.delete();
      cur = 27'($urandom_range(0, 200));
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        aq.push_back(cur);
        dq.push_back(8'($urandom));
        if ($urandom_range(0, 9) < 6) cur = cur + 27'd1;
        else cur = 27'($urandom_range(0, 400));
      end
      model(aq, dq);
      ack_delay = $urandom_range(0, 3);
      session(aq, dq, 2, $sformatf("rnd%0d", s));
    end

    // reset while a write is waiting for its acknowledge
    ack_en = 1'b0;
    dn0 = done_cnt;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    send_byte(27'h0, 8'h12);
    send_byte(27'h1, 8'h34);
    guard = 0;
    while (!ch3_req && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("mid_req_seen", 64'(ch3_req), 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    init = 1'b1;
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_drop", 64'(ch3_req), 64'd0);
    chk("mid_words", 64'(words_written), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    init = 1'b0;
    man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("late_ack_words", 64'(words_written), 64'd0);
    chk("late_ack_req", 64'(ch3_req), 64'd0);
    chk("late_ack_done", 64'(done_cnt - dn0), 64'd0);
    ack_en = 1'b1;

    chk("req_stable", 64'(stab_viol), 64'd0);
    chk("rnw_low", 64'(rnw_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
